// File: rtl/isa_pkg.sv
// Shared types and harness port map for the ISA I/O master.
package isa_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, HOLD, RESP} state_t;

   localparam logic [9:0] SEG    = 10'h300;
   localparam logic [9:0] TIMER  = 10'h301;
   localparam logic [9:0] RST1   = 10'h302;
   localparam logic [9:0] RST2   = 10'h303;
   localparam logic [9:0] SER_TX = 10'h305;
   localparam logic [9:0] SER_RX = 10'h306;
   localparam logic [9:0] BTN    = 10'h310;
   localparam logic [9:0] CNT1   = 10'h320;
   localparam logic [9:0] CNT2   = 10'h321;

endpackage

// File: rtl/isa_io_master_if.sv
// Command/response handshake plus ISA bus pins; master is the initiator view.
interface isa_io_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [9:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       rsp_timeout;
   logic [9:0] ab;
   logic       aen;
   logic       iow_n;
   logic       ior_n;
   logic [7:0] db_out;
   logic       db_oe;
   logic [7:0] db_in;
   logic       iochrdy;
   logic       busy;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, db_in, iochrdy,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, ab, aen, iow_n, ior_n,
             db_out, db_oe, busy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, db_in, iochrdy,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, ab, aen, iow_n, ior_n,
             db_out, db_oe, busy
   );
endinterface

// File: rtl/isa_io_master_sync2.sv
// Two-flop synchronizer for the asynchronous iochrdy line.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);
   logic [1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_sync <= {2{RST_VAL}};
      else          r_sync <= {r_sync[0], i_d};
   end

   assign o_q = r_sync[1];
endmodule

// File: rtl/isa_io_master.sv
// ISA 8-bit I/O cycle initiator: setup, strobe, iochrdy wait, hold, response.
module isa_io_master
   import isa_pkg::*;
#(
   parameter int SETUP_CYC   = 2,
   parameter int STROBE_CYC  = 6,
   parameter int HOLD_CYC    = 2,
   parameter int RDY_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   isa_io_master_if.master   bus
);
   state_t     r_state, w_nxt;
   logic [7:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic       r_dir;
   logic [9:0] r_ab;
   logic [7:0] r_db_out, r_rdata;
   logic       r_db_oe, r_aen, r_iow_n, r_ior_n;
   logic       r_rsp_valid, r_tmo, r_cmd_ready, r_busy;
   logic       w_rdy, w_accept, w_cap, w_tmo, w_dir, w_strb, w_cyc;

   sync2 #(.RST_VAL(1'b1)) u_rdy_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (bus.iochrdy),
      .o_q     (w_rdy)
   );

   assign w_accept  = bus.cmd_valid && r_cmd_ready;
   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
   assign w_dir     = w_accept ? bus.cmd_write : r_dir;

   always_comb begin
      w_nxt     = r_state;
      w_cnt_nxt = w_cnt_inc;
      w_cap     = 1'b0;
      w_tmo     = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = 8'd0;
            if (w_accept) w_nxt = SETUP;
         end
         SETUP: if (r_cnt == 8'(SETUP_CYC - 1)) begin
            w_nxt     = STROBE;
            w_cnt_nxt = 8'd0;
         end
         STROBE: if (r_cnt == 8'(STROBE_CYC - 1)) begin
            w_cnt_nxt = 8'd0;
            w_nxt     = w_rdy ? HOLD : WAIT;
            w_cap     = w_rdy;
         end
         WAIT: begin
            // ready wins over timeout when both land on the same cycle
            if (w_rdy || r_cnt == 8'(RDY_TIMEOUT - 1)) begin
               w_nxt     = HOLD;
               w_cnt_nxt = 8'd0;
               w_cap     = 1'b1;
               w_tmo     = !w_rdy;
            end
         end
         HOLD: if (r_cnt == 8'(HOLD_CYC - 1)) begin
            w_nxt     = RESP;
            w_cnt_nxt = 8'd0;
         end
         RESP: begin
            w_cnt_nxt = 8'd0;
            if (bus.rsp_ready) w_nxt = IDLE;
         end
         default: w_nxt = IDLE;
      endcase
   end

   assign w_strb = (w_nxt == STROBE) || (w_nxt == WAIT);
   assign w_cyc  = !((w_nxt == IDLE) || (w_nxt == RESP));

   // Bus pins are registered from the next state so they change cleanly on the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= 8'd0;
         r_dir       <= 1'b0;
         r_ab        <= 10'd0;
         r_db_out    <= 8'd0;
         r_db_oe     <= 1'b0;
         r_aen       <= 1'b1;
         r_iow_n     <= 1'b1;
         r_ior_n     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rdata     <= 8'd0;
         r_tmo       <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_nxt;
         r_cnt       <= w_cnt_nxt;
         if (w_accept) begin
            r_dir    <= bus.cmd_write;
            r_ab     <= bus.cmd_addr;
            r_db_out <= bus.cmd_write ? bus.cmd_wdata : 8'h00;
         end
         r_aen       <= !w_cyc;
         r_db_oe     <= w_cyc && w_dir;
         r_iow_n     <= !(w_strb && w_dir);
         r_ior_n     <= !(w_strb && !w_dir);
         r_rsp_valid <= (w_nxt == RESP);
         r_cmd_ready <= (w_nxt == IDLE);
         r_busy      <= (w_nxt != IDLE);
         if (w_cap) begin
            r_tmo   <= w_tmo;
            r_rdata <= r_dir ? 8'h00 : (w_tmo ? 8'hFF : bus.db_in);
         end
      end
   end

   assign bus.cmd_ready   = r_cmd_ready;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rdata;
   assign bus.rsp_timeout = r_tmo;
   assign bus.ab          = r_ab;
   assign bus.aen         = r_aen;
   assign bus.iow_n       = r_iow_n;
   assign bus.ior_n       = r_ior_n;
   assign bus.db_out      = r_db_out;
   assign bus.db_oe       = r_db_oe;
   assign bus.busy        = r_busy;
endmodule

// File: tb/tb_isa_io_master.sv
// Directed bench for isa_io_master: scoreboard of responses plus a bus-timing monitor.
module tb_isa_io_master;
   import isa_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   isa_io_master_if bus ();
   isa_io_master dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [7:0] rdata;
      logic       tmo;
   } exp_t;
   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;

   // bus monitor: pulse widths, aen-to-strobe lead, protocol violations
   int aen_cnt = 0, iow_cnt = 0, ior_cnt = 0;
   int last_aen = 0, last_iow = 0, last_ior = 0, lead = 0;
   int iow_pulses = 0, ior_pulses = 0, viol = 0;
   int rdy_k = 0, p0 = 0;

   always @(negedge clk) begin
      if (bus.iow_n === 1'b0 && bus.ior_n === 1'b0) viol++;
      if ((bus.iow_n === 1'b0 || bus.ior_n === 1'b0) && bus.aen !== 1'b0) viol++;
      if ((bus.iow_n === 1'b0 || bus.ior_n === 1'b0) && iow_cnt == 0 && ior_cnt == 0) lead = aen_cnt;
      if (bus.aen === 1'b0) aen_cnt++;
      else begin
         if (aen_cnt > 0) last_aen = aen_cnt;
         aen_cnt = 0;
      end
      if (bus.iow_n === 1'b0) iow_cnt++;
      else begin
         if (iow_cnt > 0) begin last_iow = iow_cnt; iow_pulses++; end
         iow_cnt = 0;
      end
      if (bus.ior_n === 1'b0) ior_cnt++;
      else begin
         if (ior_cnt > 0) begin last_ior = ior_cnt; ior_pulses++; end
         ior_cnt = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic w, input logic [9:0] a, input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (bus.cmd_ready === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("cmd_accept", 32'(ok), 32'd1);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input logic exp_oe, input logic [7:0] db, input int stall);
      bit ok;
      int bad, sbad;
      exp_t e;
      logic [7:0] rd0;
      logic t0;
      ok = 1'b0; bad = 0; sbad = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) begin ok = 1'b1; break; end
         if (bus.aen === 1'b0 && (bus.db_oe !== exp_oe || (exp_oe && bus.db_out !== db))) bad++;
      end
      chk("rsp_seen", 32'(ok), 32'd1);
      chk("db_drive", 32'(bad), 32'd0);
      e = sb.pop_front();
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
      chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
      rd0 = bus.rsp_rdata;
      t0  = bus.rsp_timeout;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.aen !== 1'b1 ||
             bus.rsp_rdata !== rd0 || bus.rsp_timeout !== t0) sbad++;
      end
      chk("rsp_stall", 32'(sbad), 32'd0);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.db_in     = '0;
      bus.iochrdy   = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_aen", 32'(bus.aen), 32'd1);
      chk("rst_strobes", 32'({bus.iow_n, bus.ior_n}), 32'd3);
      chk("rst_ab", 32'(bus.ab), 32'd0);
      chk("rst_db_oe", 32'(bus.db_oe), 32'd0);
      chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata}), 32'd0);
      chk("rst_ready_busy", 32'({bus.cmd_ready, bus.busy}), 32'd2);
      rst_n = 1'b1;

      // write 0x300 <- 0xA5, no wait
      p0 = ior_pulses;
      sb.push_back('{8'h00, 1'b0});
      send(1'b1, SEG, 8'hA5);
      chk("w_ab", 32'(bus.ab), 32'h300);
      get_rsp(1'b1, 8'hA5, 0);
      @(negedge clk);
      chk("w_aen_len", 32'(last_aen), 32'd10);
      chk("w_iow_len", 32'(last_iow), 32'd6);
      chk("w_lead", 32'(lead), 32'd2);
      chk("w_ior_idle", 32'(ior_pulses), 32'(p0));

      // read 0x306, no wait
      bus.db_in = 8'h3C;
      sb.push_back('{8'h3C, 1'b0});
      send(1'b0, SER_RX, 8'h00);
      get_rsp(1'b0, 8'h00, 0);
      @(negedge clk);
      chk("r_ior_len", 32'(last_ior), 32'd6);

      // read 0x320, iochrdy raised during strobe cycle 10
      bus.iochrdy = 1'b0;
      repeat (4) @(negedge clk);
      bus.db_in = 8'h5A;
      sb.push_back('{8'h5A, 1'b0});
      fork
         send(1'b0, CNT1, 8'h00);
         begin
            rdy_k = 0;
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               if (bus.ior_n === 1'b0) rdy_k++;
               if (rdy_k == 10) break;
            end
            bus.iochrdy = 1'b1;
         end
      join
      get_rsp(1'b0, 8'h00, 0);
      @(negedge clk);
      chk("wait_ior_len", 32'(last_ior), 32'd12);

      // read 0x321 with iochrdy stuck low
      bus.iochrdy = 1'b0;
      repeat (4) @(negedge clk);
      bus.db_in = 8'h99;
      sb.push_back('{8'hFF, 1'b1});
      send(1'b0, CNT2, 8'h00);
      get_rsp(1'b0, 8'h00, 0);
      @(negedge clk);
      chk("tmo_ior_len", 32'(last_ior), 32'd70);
      bus.iochrdy = 1'b1;
      repeat (4) @(negedge clk);

      // back-to-back: second command waits behind a stalled response
      bus.db_in = 8'h77;
      sb.push_back('{8'h00, 1'b0});
      sb.push_back('{8'h77, 1'b0});
      send(1'b1, TIMER, 8'h11);
      fork
         send(1'b0, BTN, 8'h00);
         get_rsp(1'b1, 8'h11, 5);
      join
      get_rsp(1'b0, 8'h00, 0);
      @(negedge clk);
      chk("b2b_ior_len", 32'(last_ior), 32'd6);
      chk("b2b_lead", 32'(lead), 32'd2);

      // reset during strobe cycle 3 of a write
      fork
         send(1'b1, RST1, 8'h5C);
         begin
            rdy_k = 0;
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               if (bus.iow_n === 1'b0) rdy_k++;
               if (rdy_k == 3) break;
            end
            rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
      join
      @(negedge clk);
      chk("mid_rst_pins", 32'({bus.iow_n, bus.aen, bus.db_oe}), 32'b110);
      chk("mid_rst_rsp", 32'({bus.rsp_valid, bus.cmd_ready}), 32'b01);
      sb.push_back('{8'h00, 1'b0});
      send(1'b1, RST2, 8'h42);
      get_rsp(1'b1, 8'h42, 0);
      @(negedge clk);
      chk("post_rst_iow_len", 32'(last_iow), 32'd6);
      chk("post_rst_aen_len", 32'(last_aen), 32'd10);
      chk("strobe_rules", 32'(viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
